core_mem_arbiter: RTL and testbench

Shares a single req/gnt/rvalid memory port between the core's instruction-fetch and data (LSU) interfaces. It sits between the riscv_core instance and a single-ported memory model in the core testbench. It adds zero cycles of latency: requests and grants pass through combinationally, and responses are routed back through an in-order outstanding-transaction FIFO. When both sides request, it arbitrates round-robin and locks each choice until that request is granted.

---
 rtl/core_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// ----------------------------------------------------------------------------
// Shares one req/gnt/rvalid memory port between the core's instruction-fetch
// and LSU interfaces with zero added latency. Requests, grants and responses
// pass through combinationally. A small in-order FIFO records which side owns
// each granted transaction so rvalid can be routed back to it. Ties are
// broken round-robin, and a choice is held until its request is granted.
//
// Parameters:
//   MAX_OUTSTANDING  granted transactions allowed to await rvalid (1..8)
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   instr_req_i/addr_i               fetch request
//   instr_gnt_o/rvalid_o/rdata_o     fetch grant and response
//   data_req_i/we_i/be_i/addr_i/wdata_i  LSU request
//   data_gnt_o/rvalid_o/rdata_o      LSU grant and response
//   mem_req_o/we_o/be_o/addr_o/wdata_o   shared memory request
//   mem_gnt_i/rvalid_i/rdata_i       memory grant and in-order response
//   err_o                            sticky: rvalid seen with nothing outstanding
// ----------------------------------------------------------------------------
module core_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    // Outstanding-owner FIFO, one bit per entry (0 = instr, 1 = data)
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [CNT_W-1:0]           count_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [PTR_W-1:0]           wr_ptr_q;

    src_e     last_src_q;
    logic     lock_valid_q;
    src_e     lock_src_q;

    logic     sel_valid;
    src_e     sel_src;
    logic     blocked;
    logic     push;
    logic     pop;
    logic     head;
    mem_cmd_t cmd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Uses the registered count only: a pop this cycle does not free a slot
    // for a grant until the next cycle.
    assign blocked = (count_q == CNT_FULL);

    // Source selection: lock first, then a lone requester, then round-robin.
    always_comb begin
        sel_valid = 1'b0;
        sel_src   = SRC_INSTR;
        if (lock_valid_q) begin
            sel_valid = 1'b1;
            sel_src   = lock_src_q;
        end else if (instr_req_i && data_req_i) begin
            sel_valid = 1'b1;
            sel_src   = (last_src_q == SRC_DATA) ? SRC_INSTR : SRC_DATA;
        end else if (instr_req_i) begin
            sel_valid = 1'b1;
            sel_src   = SRC_INSTR;
        end else if (data_req_i) begin
            sel_valid = 1'b1;
            sel_src   = SRC_DATA;
        end
    end

    // Command mux; fetches are always full-word reads.
    always_comb begin
        cmd = '0;
        if (sel_valid) begin
            if (sel_src == SRC_DATA) begin
                cmd.we    = data_we_i;
                cmd.be    = data_be_i;
                cmd.addr  = data_addr_i;
                cmd.wdata = data_wdata_i;
            end else begin
                cmd.be    = 4'hF;
                cmd.addr  = instr_addr_i;
            end
        end
    end

    assign mem_req_o   = sel_valid & ~blocked;
    assign mem_we_o    = cmd.we;
    assign mem_be_o    = cmd.be;
    assign mem_addr_o  = cmd.addr;
    assign mem_wdata_o = cmd.wdata;

    assign instr_gnt_o = mem_gnt_i & mem_req_o & (sel_src == SRC_INSTR);
    assign data_gnt_o  = mem_gnt_i & mem_req_o & (sel_src == SRC_DATA);

    assign push = mem_req_o & mem_gnt_i;
    assign pop  = mem_rvalid_i & (count_q != '0);
    assign head = fifo_q[rd_ptr_q];

    assign instr_rvalid_o = pop & ~head;
    assign data_rvalid_o  = pop & head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_q       <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            last_src_q   <= SRC_DATA;  // instr wins the first tie
            lock_valid_q <= 1'b0;
            lock_src_q   <= SRC_INSTR;
            err_o        <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sel_src;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
                last_src_q       <= sel_src;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            // Hold the selection across gnt wait states so the address seen
            // by memory cannot change under an ungranted request.
            if (mem_req_o) begin
                lock_valid_q <= ~mem_gnt_i;
                lock_src_q   <= sel_src;
            end
            if (mem_rvalid_i && (count_q == '0)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Testbench for core_mem_arbiter: directed scenarios with literal checks,
// then randomized traffic, all compared every cycle against a queue-based
// reference model of the arbitration and response-routing rules.
module tb_core_mem_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        err;

    core_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: owners of outstanding transactions, oldest first
    bit q[$];
    bit m_last;     // 1 = data
    bit m_lock_v;
    bit m_lock_s;
    bit m_err;
    bit e_igl, e_dgl; // expected grants this cycle, used by the random requesters

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last   = 1'b1;
        m_lock_v = 1'b0;
        m_lock_s = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic idle();
        rst = 0; instr_req = 0; instr_addr = 0;
        data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    // Called just after the inputs are driven (away from the rising edge).
    // Compares every output to the model, then advances the model by the
    // clock edge that follows.
    task automatic eval_cycle();
        bit sv, ss, blk, ereq, pop, hd;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] eaddr, ewd;
        #1;
        blk = (q.size() == MAXO);
        sv = 1; ss = 0;
        if (m_lock_v)                   ss = m_lock_s;
        else if (instr_req && data_req) ss = !m_last;
        else if (instr_req)             ss = 0;
        else if (data_req)              ss = 1;
        else                            sv = 0;
        ereq = sv && !blk;
        ewe = 0; ebe = 0; eaddr = 0; ewd = 0;
        if (sv && ss)  begin ewe = data_we; ebe = data_be; eaddr = data_addr; ewd = data_wdata; end
        else if (sv)   begin ebe = 4'hF; eaddr = instr_addr; end
        e_igl = mem_gnt && ereq && !ss;
        e_dgl = mem_gnt && ereq && ss;
        pop = mem_rvalid && (q.size() > 0);
        hd  = (q.size() > 0) ? q[0] : 1'b0;

        chk("mem_req",      mem_req,      ereq);
        chk("mem_we",       mem_we,       ewe);
        chk("mem_be",       mem_be,       ebe);
        chk("mem_addr",     mem_addr,     eaddr);
        chk("mem_wdata",    mem_wdata,    ewd);
        chk("instr_gnt",    instr_gnt,    e_igl);
        chk("data_gnt",     data_gnt,     e_dgl);
        chk("instr_rvalid", instr_rvalid, pop && !hd);
        chk("data_rvalid",  data_rvalid,  pop && hd);
        chk("instr_rdata",  instr_rdata,  mem_rdata);
        chk("data_rdata",   data_rdata,   mem_rdata);
        chk("err",          err,          m_err);

        if (rst) begin
            model_reset();
        end else begin
            if (mem_rvalid && q.size() == 0) m_err = 1;
            if (pop) void'(q.pop_front());
            if (ereq && mem_gnt) begin
                q.push_back(ss);
                m_last   = ss;
                m_lock_v = 0;
            end else if (ereq) begin
                m_lock_v = 1;
                m_lock_s = ss;
            end
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        idle(); rst = 1; eval_cycle(); nxt();
    endtask

    bit          ip, dp;        // random requesters holding a request
    logic [31:0] ia, da, dwd;
    logic        dwe;
    logic [3:0]  dbe;

    initial begin
        idle();
        rst = 1;
        model_reset();
        nxt();                              // one edge with reset applied
        do_reset();

        // Reset values
        idle(); eval_cycle();
        chk("rst mem_req", mem_req, 0);   chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_be", mem_be, 0);     chk("rst err", err, 0);
        chk("rst ignt", instr_gnt, 0);    chk("rst dgnt", data_gnt, 0);
        nxt();

        // Single fetch
        idle(); instr_req = 1; instr_addr = 32'h80; mem_gnt = 1; eval_cycle();
        chk("fetch addr", mem_addr, 32'h80); chk("fetch be", mem_be, 4'hF);
        chk("fetch gnt", instr_gnt, 1);
        nxt();
        idle(); mem_rvalid = 1; mem_rdata = 32'h13; eval_cycle();
        chk("fetch rvalid", instr_rvalid, 1); chk("fetch rdata", instr_rdata, 32'h13);
        chk("fetch drvalid", data_rvalid, 0);
        nxt();

        // Tie round-robin from reset: instr, data, instr, data
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 4) begin
                instr_req = 1; instr_addr = 32'h1000 + i;
                data_req = 1; data_be = 4'hF; data_addr = 32'h2000 + i;
                mem_gnt = 1;
            end
            if (i > 0) begin mem_rvalid = 1; mem_rdata = 32'hA0 + i; end
            eval_cycle();
            if (i < 4) begin
                chk("rr ignt", instr_gnt, (i % 2) == 0);
                chk("rr dgnt", data_gnt,  (i % 2) == 1);
            end
            if (i > 0) begin
                chk("rr irv", instr_rvalid, (i % 2) == 1);
                chk("rr drv", data_rvalid,  (i % 2) == 0);
            end
            nxt();
        end

        // Lock under wait states: data stalls 3 cycles while instr arrives
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 4) begin
                data_req = 1; data_we = 1; data_be = 4'h3;
                data_addr = 32'h100; data_wdata = 32'hDEADBEEF;
            end
            if (i >= 1) begin instr_req = 1; instr_addr = 32'h200; end
            mem_gnt = (i >= 3);
            eval_cycle();
            if (i < 4) begin
                chk("lock addr", mem_addr, 32'h100); chk("lock we", mem_we, 1);
                chk("lock dgnt", data_gnt, i == 3); chk("lock ignt", instr_gnt, 0);
            end else begin
                chk("lock next ignt", instr_gnt, 1); chk("lock next addr", mem_addr, 32'h200);
            end
            nxt();
        end
        idle(); mem_rvalid = 1; eval_cycle(); chk("lock drv", data_rvalid, 1); nxt();
        idle(); mem_rvalid = 1; eval_cycle(); chk("lock irv", instr_rvalid, 1); nxt();

        // Full block
        idle(); instr_req = 1; instr_addr = 32'h300; mem_gnt = 1; eval_cycle(); nxt();
        idle(); data_req = 1; data_be = 4'hF; data_addr = 32'h304; mem_gnt = 1; eval_cycle(); nxt();
        idle(); instr_req = 1; instr_addr = 32'h308; mem_gnt = 1; eval_cycle();
        chk("full req", mem_req, 0); chk("full ignt", instr_gnt, 0); nxt();
        idle(); instr_req = 1; instr_addr = 32'h308; mem_gnt = 1; mem_rvalid = 1; eval_cycle();
        chk("full pop req", mem_req, 0); chk("full pop irv", instr_rvalid, 1); nxt();
        idle(); instr_req = 1; instr_addr = 32'h308; mem_gnt = 1; eval_cycle();
        chk("unblock req", mem_req, 1); chk("unblock ignt", instr_gnt, 1); nxt();
        idle(); mem_rvalid = 1; eval_cycle(); chk("drain drv", data_rvalid, 1); nxt();
        idle(); mem_rvalid = 1; eval_cycle(); chk("drain irv", instr_rvalid, 1); nxt();

        // Simultaneous push/pop
        idle(); data_req = 1; data_be = 4'hF; data_addr = 32'h400; mem_gnt = 1; eval_cycle();
        chk("pp dgnt", data_gnt, 1); nxt();
        idle(); instr_req = 1; instr_addr = 32'h404; mem_gnt = 1; mem_rvalid = 1; eval_cycle();
        chk("pp drv", data_rvalid, 1); chk("pp ignt", instr_gnt, 1); nxt();
        idle(); mem_rvalid = 1; eval_cycle();
        chk("pp irv", instr_rvalid, 1); chk("pp no drv", data_rvalid, 0); nxt();

        // Error: rvalid with nothing outstanding
        idle(); mem_rvalid = 1; eval_cycle();
        chk("err irv", instr_rvalid, 0); chk("err drv", data_rvalid, 0); nxt();
        for (int i = 0; i < 2; i++) begin
            idle(); eval_cycle(); chk("err sticky", err, 1); nxt();
        end

        // Reset with two outstanding
        idle(); instr_req = 1; instr_addr = 32'h500; mem_gnt = 1; eval_cycle(); nxt();
        idle(); data_req = 1; data_be = 4'hF; data_addr = 32'h504; mem_gnt = 1; eval_cycle(); nxt();
        do_reset();
        idle(); eval_cycle(); chk("post rst err", err, 0); chk("post rst req", mem_req, 0); nxt();
        idle(); mem_rvalid = 1; eval_cycle();
        chk("post rst irv", instr_rvalid, 0); chk("post rst drv", data_rvalid, 0); nxt();
        do_reset();

        // Randomized traffic
        ip = 0; dp = 0;
        for (int n = 0; n < 4000; n++) begin
            if (!ip && ($urandom_range(0, 9) < 5)) begin ip = 1; ia = $urandom; end
            if (!dp && ($urandom_range(0, 9) < 5)) begin
                dp = 1; da = $urandom; dwd = $urandom;
                dwe = $urandom_range(0, 1); dbe = $urandom_range(0, 15);
            end
            rst = 0;
            instr_req = ip; instr_addr = ip ? ia : $urandom;
            data_req = dp;
            data_addr = dp ? da : $urandom;  data_wdata = dp ? dwd : $urandom;
            data_we = dp ? dwe : $urandom_range(0, 1); data_be = dp ? dbe : $urandom_range(0, 15);
            mem_gnt = ($urandom_range(0, 9) < 7);
            mem_rvalid = (q.size() > 0) && ($urandom_range(0, 9) < 6);
            mem_rdata = $urandom;
            eval_cycle();
            if (e_igl) ip = 0;
            if (e_dgl) dp = 0;
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
